// File: rtl/freq_meas.sv
// freq_meas -- gated frequency counter.
// Counts rising edges of an asynchronous input over a fixed window of
// GATE_CYCLES clk_in cycles. The result is saturated at 2^CW-1, and ovf
// reports that the window saturated.
// Optional feature: define FREQ_MEAS_RANGE_CHECK_EN to add the in_range
// output, which compares each result against [LO_LIMIT, HI_LIMIT].
module freq_meas #(
  parameter int            GATE_CYCLES = 100000,
  parameter int            CW          = 18,
  parameter logic [CW-1:0] LO_LIMIT    = {CW{1'b0}},
  parameter logic [CW-1:0] HI_LIMIT    = {CW{1'b1}}
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          en,
  input  logic          sig_in,
  output logic [CW-1:0] freq_count,
  output logic          valid,
  output logic          busy,
  output logic          ovf
`ifdef FREQ_MEAS_RANGE_CHECK_EN
  ,
  output logic          in_range
`endif
);

  localparam int            GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0] GATE_ONE  = GW'(1'b1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Saturating increment: holds at CNT_MAX instead of wrapping.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] cnt, input logic inc);
    if (inc && (cnt != CNT_MAX)) begin
      sat_add = cnt + CNT_ONE;
    end else begin
      sat_add = cnt;
    end
  endfunction

  state_t        state_r;
  state_t        state_nx_s;
  logic          clr_s;
  logic          last_s;
  logic          sync1_r;
  logic          sync2_r;
  logic          sync3_r;
  logic          edge_s;
  logic          at_max_s;
  logic [GW-1:0] gate_cnt_r;
  logic [CW-1:0] edge_cnt_r;
  logic          win_ovf_r;
  logic [CW-1:0] result_s;
  logic          ovf_fin_s;
  logic [CW-1:0] freq_count_r;
  logic          valid_r;
  logic          busy_r;
  logic          ovf_r;

  // Two-flop synchronizer plus a history flop for rising-edge detection.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= sig_in;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  assign edge_s    = sync2_r & ~sync3_r;
  assign at_max_s  = edge_s & (edge_cnt_r == CNT_MAX);
  assign result_s  = sat_add(edge_cnt_r, edge_s);
  assign ovf_fin_s = win_ovf_r | at_max_s;

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode; clr_s opens a fresh window, last_s marks its final cycle.
  always_comb begin
    state_nx_s = state_r;
    clr_s      = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (en) begin
          state_nx_s = COUNT;
          clr_s      = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      COUNT: begin
        if (!en) begin
          state_nx_s = IDLE;
        end else if (gate_cnt_r == GATE_LAST) begin
          state_nx_s = DONE;
          last_s     = 1'b1;
        end else begin
          state_nx_s = COUNT;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Window counters, result capture and registered status decodes.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      gate_cnt_r   <= {GW{1'b0}};
      edge_cnt_r   <= {CW{1'b0}};
      win_ovf_r    <= 1'b0;
      freq_count_r <= {CW{1'b0}};
      ovf_r        <= 1'b0;
      valid_r      <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      valid_r <= (state_nx_s == DONE);
      busy_r  <= (state_nx_s == COUNT);
      if (clr_s) begin
        gate_cnt_r <= {GW{1'b0}};
        edge_cnt_r <= {CW{1'b0}};
        win_ovf_r  <= 1'b0;
      end else if (state_r == COUNT) begin
        gate_cnt_r <= gate_cnt_r + GATE_ONE;
        edge_cnt_r <= result_s;
        win_ovf_r  <= ovf_fin_s;
      end
      if (last_s) begin
        freq_count_r <= result_s;
        ovf_r        <= ovf_fin_s;
      end
    end
  end

  assign freq_count = freq_count_r;
  assign valid      = valid_r;
  assign busy       = busy_r;
  assign ovf        = ovf_r;

`ifdef FREQ_MEAS_RANGE_CHECK_EN
  logic in_range_r;

  // Range verdict captured alongside the window result and held with it.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      in_range_r <= 1'b0;
    end else if (last_s) begin
      in_range_r <= (result_s >= LO_LIMIT) && (result_s <= HI_LIMIT) && !ovf_fin_s;
    end
  end

  assign in_range = in_range_r;
`else
  logic unused_limits_s;
  assign unused_limits_s = ^{LO_LIMIT, HI_LIMIT};
`endif

endmodule

// File: tb/tb_freq_meas.sv
// Self-checking bench for freq_meas: two instances (wide/long-gate and
// narrow/short-gate) driven with periodic, constant and random waveforms,
// checked against a behavioural edge-timestamp model.
module tb_freq_meas;

  localparam int G0 = 1000;
  localparam int G1 = 100;
  localparam int M0 = 262143;
  localparam int M1 = 15;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic        en0    = 1'b0;
  logic        en1    = 1'b0;
  logic        sig0   = 1'b0;
  logic        sig1   = 1'b0;
  logic [17:0] fc0;
  logic [3:0]  fc1;
  logic        v0, v1, b0, b1, o0, o1;
`ifdef FREQ_MEAS_RANGE_CHECK_EN
  logic        ir0, ir1;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   mode[2];
  int   per[2];
  int   phase[2];
  int   rem[2];
  logic cval[2];
  logic lvl[2];
  logic prev[2];
  int   det[2][$];
  int   vq[2][$];
  int   fq[2][$];
  logic oq[2][$];
  logic iq[2][$];

  always #5 clk_in = ~clk_in;

  freq_meas #(.GATE_CYCLES(G0), .CW(18), .LO_LIMIT(18'd9), .HI_LIMIT(18'd11)) u_dut0 (
    .clk_in(clk_in), .reset(reset), .en(en0), .sig_in(sig0),
    .freq_count(fc0), .valid(v0), .busy(b0), .ovf(o0)
`ifdef FREQ_MEAS_RANGE_CHECK_EN
    , .in_range(ir0)
`endif
  );

  freq_meas #(.GATE_CYCLES(G1), .CW(4), .LO_LIMIT(4'd0), .HI_LIMIT(4'd15)) u_dut1 (
    .clk_in(clk_in), .reset(reset), .en(en1), .sig_in(sig1),
    .freq_count(fc1), .valid(v1), .busy(b1), .ovf(o1)
`ifdef FREQ_MEAS_RANGE_CHECK_EN
    , .in_range(ir1)
`endif
  );

  function automatic int gate_of(input int id);
    return (id == 0) ? G0 : G1;
  endfunction

  function automatic int max_of(input int id);
    return (id == 0) ? M0 : M1;
  endfunction

  // Model: number of detected rising edges that fall inside the window ending at v.
  function automatic int model_cnt(input int id, input int v);
    int c;
    c = 0;
    for (int j = 0; j < det[id].size(); j++)
      if (det[id][j] > v - gate_of(id) && det[id][j] <= v) c++;
    return c;
  endfunction

  function automatic int sat_of(input int id, input int c);
    return (c > max_of(id)) ? max_of(id) : c;
  endfunction

`ifdef FREQ_MEAS_RANGE_CHECK_EN
  function automatic logic exp_ir(input int id, input int c);
    int lo, hi, f;
    lo = (id == 0) ? 9 : 0;
    hi = (id == 0) ? 11 : 15;
    f  = sat_of(id, c);
    return (f >= lo) && (f <= hi) && (c <= max_of(id));
  endfunction
`endif

  // One clk_in cycle: drive sig_in, record edge timestamps, capture valid events.
  task automatic step();
    logic s[2];
    for (int k = 0; k < 2; k++) begin
      case (mode[k])
        0: s[k] = cval[k];
        1: s[k] = (((cyc + phase[k]) % per[k]) < (per[k] / 2));
        default: begin
          if (rem[k] == 0) begin
            lvl[k] = ~lvl[k];
            rem[k] = $urandom_range(2, 12);
          end
          rem[k]--;
          s[k] = lvl[k];
        end
      endcase
    end
    sig0 = s[0];
    sig1 = s[1];
    @(posedge clk_in);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (reset) prev[k] = 1'b0;
      else begin
        if (s[k] && !prev[k]) det[k].push_back(cyc + 2);
        prev[k] = s[k];
      end
    end
    @(negedge clk_in);
    if (v0) begin
      vq[0].push_back(cyc); fq[0].push_back(int'(fc0)); oq[0].push_back(o0);
`ifdef FREQ_MEAS_RANGE_CHECK_EN
      iq[0].push_back(ir0);
`endif
    end
    if (v1) begin
      vq[1].push_back(cyc); fq[1].push_back(int'(fc1)); oq[1].push_back(o1);
`ifdef FREQ_MEAS_RANGE_CHECK_EN
      iq[1].push_back(ir1);
`endif
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_q();
    for (int k = 0; k < 2; k++) begin
      vq[k].delete(); fq[k].delete(); oq[k].delete(); iq[k].delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en0 = 1'b0; en1 = 1'b0;
    run(3);
    n_tests++; if (fc0 !== 18'd0) begin n_fail++; $display("FAIL reset_fc0: got %0d expected 0", fc0); end
    n_tests++; if ({v0, b0, o0} !== 3'b000) begin n_fail++; $display("FAIL reset_flags0: got %b expected 000", {v0, b0, o0}); end
    n_tests++; if (fc1 !== 4'd0) begin n_fail++; $display("FAIL reset_fc1: got %0d expected 0", fc1); end
    n_tests++; if ({v1, b1, o1} !== 3'b000) begin n_fail++; $display("FAIL reset_flags1: got %b expected 000", {v1, b1, o1}); end
    reset = 1'b0;
    run(2);
  endtask

  task automatic test_periodic();
    int s, g, nsteps, nexp, c;
    clear_q();
    mode[0] = 1; per[0] = 100; phase[0] = $urandom_range(0, 99);
    mode[1] = 1; per[1] = $urandom_range(4, 40); phase[1] = $urandom_range(0, 39);
    run(20);
    en0 = 1'b1; en1 = 1'b1;
    step();
    s = cyc;
    n_tests++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL periodic_busy: got %b expected 1", b0); end
    nsteps = 3 * (G0 + 1);
    run(nsteps);
    en0 = 1'b0; en1 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      g = gate_of(k);
      nexp = (nsteps - g) / (g + 1) + 1;
      n_tests++; if (vq[k].size() != nexp) begin n_fail++; $display("FAIL periodic_nvalid%0d: got %0d expected %0d", k, vq[k].size(), nexp); end
      for (int i = 0; i < vq[k].size(); i++) begin
        c = model_cnt(k, vq[k][i]);
        n_tests++; if (vq[k][i] != s + g + i * (g + 1)) begin n_fail++; $display("FAIL periodic_time%0d: got %0d expected %0d", k, vq[k][i] - s, g + i * (g + 1)); end
        n_tests++; if (fq[k][i] != sat_of(k, c) || oq[k][i] !== (c > max_of(k))) begin n_fail++; $display("FAIL periodic_count%0d: got %0d/%b expected %0d/%b", k, fq[k][i], oq[k][i], sat_of(k, c), c > max_of(k)); end
      end
    end
    for (int i = 0; i < vq[0].size(); i++) begin
      n_tests++; if (fq[0][i] != 10 || oq[0][i] !== 1'b0) begin n_fail++; $display("FAIL periodic_p100: got %0d/%b expected 10/0", fq[0][i], oq[0][i]); end
    end
    run(3);
  endtask

  task automatic test_saturation();
    clear_q();
    mode[1] = 1; per[1] = 4; phase[1] = $urandom_range(0, 3);
    run(10);
    en1 = 1'b1;
    step();
    run(2 * (G1 + 1));
    en1 = 1'b0;
    n_tests++; if (vq[1].size() != 2) begin n_fail++; $display("FAIL sat_nvalid: got %0d expected 2", vq[1].size()); end
    for (int i = 0; i < vq[1].size(); i++) begin
      n_tests++; if (fq[1][i] != 15 || oq[1][i] !== 1'b1) begin n_fail++; $display("FAIL sat_count: got %0d/%b expected 15/1", fq[1][i], oq[1][i]); end
`ifdef FREQ_MEAS_RANGE_CHECK_EN
      n_tests++; if (iq[1][i] !== 1'b0) begin n_fail++; $display("FAIL sat_in_range: got %b expected 0", iq[1][i]); end
`endif
    end
    run(3);
  endtask

  task automatic test_static();
    for (int lv = 0; lv < 2; lv++) begin
      clear_q();
      mode[0] = 0; mode[1] = 0; cval[0] = lv[0]; cval[1] = lv[0];
      run(10);
      en0 = 1'b1; en1 = 1'b1;
      step();
      run(G0 + 1);
      en0 = 1'b0; en1 = 1'b0;
      n_tests++; if (vq[0].size() != 1 || vq[1].size() != 9) begin n_fail++; $display("FAIL static_nvalid: got %0d,%0d expected 1,9", vq[0].size(), vq[1].size()); end
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < vq[k].size(); i++) begin
          n_tests++; if (fq[k][i] != 0 || oq[k][i] !== 1'b0) begin n_fail++; $display("FAIL static_level%0d_dut%0d: got %0d/%b expected 0/0", lv, k, fq[k][i], oq[k][i]); end
        end
      run(3);
    end
  endtask

  task automatic test_random();
    int s, g, nsteps, nexp, c;
    clear_q();
    for (int k = 0; k < 2; k++) begin
      mode[k] = 2; rem[k] = 0; lvl[k] = $urandom_range(0, 1);
    end
    run(15);
    en0 = 1'b1; en1 = 1'b1;
    step();
    s = cyc;
    nsteps = 3 * (G0 + 1);
    run(nsteps);
    en0 = 1'b0; en1 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      g = gate_of(k);
      nexp = (nsteps - g) / (g + 1) + 1;
      n_tests++; if (vq[k].size() != nexp) begin n_fail++; $display("FAIL random_nvalid%0d: got %0d expected %0d", k, vq[k].size(), nexp); end
      for (int i = 0; i < vq[k].size(); i++) begin
        c = model_cnt(k, vq[k][i]);
        n_tests++; if (vq[k][i] != s + g + i * (g + 1)) begin n_fail++; $display("FAIL random_time%0d: got %0d expected %0d", k, vq[k][i] - s, g + i * (g + 1)); end
        n_tests++; if (fq[k][i] != sat_of(k, c) || oq[k][i] !== (c > max_of(k))) begin n_fail++; $display("FAIL random_count%0d: got %0d/%b expected %0d/%b", k, fq[k][i], oq[k][i], sat_of(k, c), c > max_of(k)); end
`ifdef FREQ_MEAS_RANGE_CHECK_EN
        n_tests++; if (iq[k][i] !== exp_ir(k, c)) begin n_fail++; $display("FAIL random_in_range%0d: got %b expected %b", k, iq[k][i], exp_ir(k, c)); end
`endif
      end
    end
    run(3);
  endtask

  task automatic test_en_drop();
    int s, c, ef;
    logic eo;
    clear_q();
    mode[0] = 2; rem[0] = 0;
    run(10);
    en0 = 1'b1;
    step();
    s = cyc;
    run(G0);
    ef = -1; eo = 1'b0;
    n_tests++;
    if (vq[0].size() != 1 || vq[0][0] != s + G0) begin
      n_fail++; $display("FAIL drop_first_valid: got %0d events expected 1 at +%0d", vq[0].size(), G0);
    end else begin
      c = model_cnt(0, vq[0][0]); ef = sat_of(0, c); eo = (c > M0);
    end
    run(500);
    n_tests++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL drop_busy_before: got %b expected 1", b0); end
    en0 = 1'b0;
    step();
    n_tests++; if (b0 !== 1'b0) begin n_fail++; $display("FAIL drop_busy_after: got %b expected 0", b0); end
    run(G0 + 100);
    n_tests++; if (vq[0].size() != 1) begin n_fail++; $display("FAIL drop_no_valid: got %0d events expected 1", vq[0].size()); end
    n_tests++; if (int'(fc0) != ef || o0 !== eo) begin n_fail++; $display("FAIL drop_hold: got %0d/%b expected %0d/%b", fc0, o0, ef, eo); end
  endtask

  task automatic test_reset_mid();
    int r, c;
    clear_q();
    mode[0] = 1; per[0] = 100; phase[0] = $urandom_range(0, 99);
    mode[1] = 2; rem[1] = 0;
    en0 = 1'b1; en1 = 1'b1;
    run(G0 + 300);
    reset = 1'b1;
    step();
    r = cyc;
    n_tests++; if (fc0 !== 18'd0 || {v0, b0, o0} !== 3'b000) begin n_fail++; $display("FAIL midreset_dut0: got %0d/%b expected 0/000", fc0, {v0, b0, o0}); end
    n_tests++; if (fc1 !== 4'd0 || {v1, b1, o1} !== 3'b000) begin n_fail++; $display("FAIL midreset_dut1: got %0d/%b expected 0/000", fc1, {v1, b1, o1}); end
    reset = 1'b0;
    clear_q();
    run(G0 + 2);
    en0 = 1'b0; en1 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (vq[k].size() == 0) begin
        n_fail++; $display("FAIL midreset_valid%0d: got no valid expected one at +%0d", k, gate_of(k) + 1);
      end else if (vq[k][0] != r + gate_of(k) + 1) begin
        n_fail++; $display("FAIL midreset_valid%0d: got +%0d expected +%0d", k, vq[k][0] - r, gate_of(k) + 1);
      end
      if (vq[k].size() != 0) begin
        c = model_cnt(k, vq[k][0]);
        n_tests++; if (fq[k][0] != sat_of(k, c) || oq[k][0] !== (c > max_of(k))) begin n_fail++; $display("FAIL midreset_count%0d: got %0d/%b expected %0d/%b", k, fq[k][0], oq[k][0], sat_of(k, c), c > max_of(k)); end
      end
    end
    run(3);
  endtask

  task automatic test_range();
    int exp_f;
    for (int t = 0; t < 2; t++) begin
      clear_q();
      mode[0] = 1; per[0] = (t == 0) ? 100 : 50; phase[0] = $urandom_range(0, per[0] - 1);
      exp_f = (t == 0) ? 10 : 20;
      run(10);
      en0 = 1'b1;
      step();
      run(G0);
      en0 = 1'b0;
      n_tests++;
      if (vq[0].size() != 1) begin
        n_fail++; $display("FAIL range_nvalid_p%0d: got %0d expected 1", per[0], vq[0].size());
      end else if (fq[0][0] != exp_f) begin
        n_fail++; $display("FAIL range_count_p%0d: got %0d expected %0d", per[0], fq[0][0], exp_f);
      end
`ifdef FREQ_MEAS_RANGE_CHECK_EN
      if (vq[0].size() != 0) begin
        n_tests++; if (iq[0][0] !== (t == 0)) begin n_fail++; $display("FAIL range_in_range_p%0d: got %b expected %b", per[0], iq[0][0], t == 0); end
      end
`endif
      run(3);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mode[k] = 0; per[k] = 4; phase[k] = 0; rem[k] = 0;
      cval[k] = 1'b0; lvl[k] = 1'b0; prev[k] = 1'b0;
    end
    test_reset();
    test_periodic();
    test_saturation();
    test_static();
    test_random();
    test_en_drop();
    test_reset_mid();
    test_range();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
